// File: rtl/sync_rx_fifo.sv
// Single-clock receive FIFO between the CDC output and the frame parser.
// Optional occupancy statistics are enabled with `define SYNC_RX_FIFO_STATS_EN.
`timescale 1ns/1ps
module sync_rx_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = 12,
    parameter bit FWFT         = 1'b0
) (
    input  logic                     clkIn,
    input  logic                     rstIn,
    input  logic                     wrEnIn,
    input  logic [DATA_WIDTH-1:0]    wrDataIn,
    output logic                     fullOut,
    output logic                     almostFullOut,
    output logic                     overflowOut,
    input  logic                     rdEnIn,
    output logic [DATA_WIDTH-1:0]    rdDataOut,
    output logic                     rdDataValidOut,
    output logic                     emptyOut,
    output logic [$clog2(DEPTH):0]   countOut
`ifdef SYNC_RX_FIFO_STATS_EN
    ,
    output logic [15:0]              dropCountOut,
    output logic [$clog2(DEPTH):0]   highWaterOut
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wrPtr;
    logic [AW-1:0]         rdPtr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         countNext;
    logic                  rdAccept;
    logic                  wrAccept;

    // Both read modes pop on rdEnIn while non-empty; a full FIFO still
    // takes a write when a pop happens on the same edge.
    assign rdAccept = !rstIn && rdEnIn && !emptyOut;
    assign wrAccept = !rstIn && wrEnIn && (!fullOut || rdAccept);

    always_comb begin
        countNext = count;
        unique case ({wrAccept, rdAccept})
            2'b10:   countNext = count + CW'(1);
            2'b01:   countNext = count - CW'(1);
            default: countNext = count;
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (wrAccept) begin
            mem[wrPtr] <= wrDataIn;
        end
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            wrPtr         <= '0;
            rdPtr         <= '0;
            count         <= '0;
            fullOut       <= 1'b0;
            almostFullOut <= 1'b0;
            emptyOut      <= 1'b1;
            overflowOut   <= 1'b0;
        end else begin
            if (wrAccept) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (rdAccept) begin
                rdPtr <= rdPtr + AW'(1);
            end
            count         <= countNext;
            fullOut       <= (countNext == DEPTH_C);
            almostFullOut <= (countNext >= AFULL_C);
            emptyOut      <= (countNext == '0);
            overflowOut   <= wrEnIn && !wrAccept;
        end
    end

    assign countOut = count;

    generate
        if (FWFT) begin : gFwft
            // Head entry is shown combinationally; zero while empty so the
            // output is clean after reset.
            assign rdDataValidOut = !emptyOut;
            assign rdDataOut      = emptyOut ? '0 : mem[rdPtr];
        end else begin : gStd
            logic [DATA_WIDTH-1:0] rdDataReg;
            logic                  rdValidReg;

            always_ff @(posedge clkIn) begin
                if (rstIn) begin
                    rdDataReg  <= '0;
                    rdValidReg <= 1'b0;
                end else begin
                    rdValidReg <= rdAccept;
                    if (rdAccept) begin
                        rdDataReg <= mem[rdPtr];
                    end
                end
            end

            assign rdDataValidOut = rdValidReg;
            assign rdDataOut      = rdDataReg;
        end
    endgenerate

`ifdef SYNC_RX_FIFO_STATS_EN
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            dropCountOut <= '0;
            highWaterOut <= '0;
        end else begin
            if (wrEnIn && !wrAccept && (dropCountOut != 16'hFFFF)) begin
                dropCountOut <= dropCountOut + 16'd1;
            end
            // Track the post-edge count so the mark lines up with countOut.
            if (countNext > highWaterOut) begin
                highWaterOut <= countNext;
            end
        end
    end
`endif

endmodule
